cart_mem_arbiter: RTL and testbench

Shares the single-port cartridge RAM between the HPS download stream and the console's cartridge read port. Download bytes are buffered in a small write FIFO and drained into the RAM in cycles the console does not need. The block produces a console hold-in-reset signal that stays active until the download has ended and every buffered byte is committed. It sits between hps_io, the cartridge RAM and cv_console.

---
 rtl/cart_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_arbiter.sv
// Cartridge RAM arbiter: buffers HPS download bytes in a small FIFO and drains them
// into the single-port RAM around console reads, holding the console in reset until done.
module cart_mem_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [24:0]       dl_addr_i,
    input  logic [7:0]        dl_data_i,
    output logic              dl_wait_o,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [7:0]        cpu_data_o,
    output logic              cpu_valid_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_data_o,
    input  logic [7:0]        mem_q_i,
    output logic              hold_reset_o,
    output logic              load_done_o,
    output logic              overflow_o
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(WBUF_DEPTH);
    localparam logic [CW-1:0] WAIT_CNT = CW'(WBUF_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
    logic [7:0]        buf_data [WBUF_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              pend_v;
    logic [ADDR_W-1:0] pend_a;
    logic              rd_d;

    logic              dl_active_q;
    logic              armed;
    logic              hold_q;
    logic              boot;

    logic              in_window;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic              pop;

    assign in_window = (dl_addr_i[24:ADDR_W] == '0);
    assign full      = (count == FULL_CNT);
    // A full FIFO refuses the push even though a pop happens in the same cycle.
    assign push_ok   = dl_wr_i && in_window && !full;
    assign drop      = dl_wr_i && in_window && full;
    assign pop       = (state_nx == WR);

    always_comb begin
        state_nx = IDLE;
        if (full) begin
            state_nx = WR;
        end else if (pend_v || cpu_req_i) begin
            state_nx = RD;
        end else if (count != '0) begin
            state_nx = WR;
        end
    end

    assign hold_reset_o = boot | dl_active_i | (count != '0) | (state == WR);
    assign load_done_o  = armed & hold_q & ~hold_reset_o;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            buf_addr[wr_ptr] <= dl_addr_i[ADDR_W-1:0];
            buf_data[wr_ptr] <= dl_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            pend_v      <= 1'b0;
            pend_a      <= '0;
            mem_addr_o  <= '0;
            mem_we_o    <= 1'b0;
            mem_data_o  <= '0;
            rd_d        <= 1'b0;
            cpu_data_o  <= '0;
            cpu_valid_o <= 1'b0;
            dl_wait_o   <= 1'b0;
            overflow_o  <= 1'b0;
            dl_active_q <= 1'b0;
            armed       <= 1'b0;
            hold_q      <= 1'b1;
            boot        <= 1'b1;
        end else begin
            state    <= state_nx;
            mem_we_o <= 1'b0;
            case (state_nx)
                RD: begin
                    mem_addr_o <= cpu_req_i ? cpu_addr_i : pend_a;
                end
                WR: begin
                    mem_addr_o <= buf_addr[rd_ptr];
                    mem_data_o <= buf_data[rd_ptr];
                    mem_we_o   <= 1'b1;
                end
                default: begin
                end
            endcase

            // An arriving request is served directly when RD wins; otherwise it replaces the pending one.
            if (state_nx == RD) begin
                pend_v <= 1'b0;
            end else if (cpu_req_i) begin
                pend_v <= 1'b1;
                pend_a <= cpu_addr_i;
            end

            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop);

            rd_d        <= (state == RD);
            cpu_valid_o <= rd_d;
            if (rd_d) begin
                cpu_data_o <= mem_q_i;
            end

            dl_wait_o   <= (count >= WAIT_CNT);
            dl_active_q <= dl_active_i;

            if (drop) begin
                overflow_o <= 1'b1;
            end else if (dl_active_i && !dl_active_q) begin
                overflow_o <= 1'b0;
            end

            boot   <= 1'b0;
            hold_q <= hold_reset_o;
            if (dl_active_i) begin
                armed <= 1'b1;
            end else if (load_done_o) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed bench for cart_mem_arbiter with a registered-read RAM model attached.
module tb_cart_mem_arbiter;

    localparam int ADDR_W     = 15;
    localparam int WBUF_DEPTH = 4;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              dl_active_i;
    logic              dl_wr_i;
    logic [24:0]       dl_addr_i;
    logic [7:0]        dl_data_i;
    logic              dl_wait_o;
    logic              cpu_req_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [7:0]        cpu_data_o;
    logic              cpu_valid_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [7:0]        mem_data_o;
    logic [7:0]        mem_q_i;
    logic              hold_reset_o;
    logic              load_done_o;
    logic              overflow_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [32768];
    int         cyc = 0;
    int         wlog_addr [$];
    int         wlog_data [$];
    int         wlog_cyc  [$];

    cart_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .WBUF_DEPTH(WBUF_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .dl_active_i (dl_active_i),
        .dl_wr_i     (dl_wr_i),
        .dl_addr_i   (dl_addr_i),
        .dl_data_i   (dl_data_i),
        .dl_wait_o   (dl_wait_o),
        .cpu_req_i   (cpu_req_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_valid_o (cpu_valid_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_data_o  (mem_data_o),
        .mem_q_i     (mem_q_i),
        .hold_reset_o(hold_reset_o),
        .load_done_o (load_done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Read-before-write single-port RAM: q is the old contents, one clock after the address.
    always @(posedge clk_i) begin
        mem_q_i <= ram[mem_addr_o];
        if (mem_we_o) begin
            ram[mem_addr_o] = mem_data_o;
            wlog_addr.push_back(int'(mem_addr_o));
            wlog_data.push_back(int'(mem_data_o));
            wlog_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs;
        dl_active_i = 1'b0;
        dl_wr_i     = 1'b0;
        dl_addr_i   = '0;
        dl_data_i   = '0;
        cpu_req_i   = 1'b0;
        cpu_addr_i  = '0;
    endtask

    task automatic test_reset;
        int n0;
        reset_n_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        total++;
        if ({mem_we_o, cpu_valid_o, dl_wait_o, load_done_o, overflow_o} !== 5'b0 ||
            mem_addr_o !== '0 || mem_data_o !== '0 || cpu_data_o !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b vld=%b wait=%b done=%b ovf=%b addr=%h data=%h q=%h, want all 0",
                     mem_we_o, cpu_valid_o, dl_wait_o, load_done_o, overflow_o, mem_addr_o, mem_data_o, cpu_data_o);
        end
        total++;
        if (hold_reset_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_hold: got %b want 1", hold_reset_o);
        end
        next_cycle();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (hold_reset_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_before_first_clk: got %b want 1", hold_reset_o);
        end
        next_cycle();
        @(negedge clk_i);
        total++;
        if (hold_reset_o !== 1'b0) begin
            bad++;
            $display("FAIL hold_after_first_clk: got %b want 0", hold_reset_o);
        end

        // Buffer three bytes behind continuous reads, then reset in the middle.
        next_cycle();
        n0 = wlog_addr.size();
        dl_active_i = 1'b1;
        cpu_req_i   = 1'b1;
        cpu_addr_i  = 15'h0200;
        for (int c = 0; c < 3; c++) begin
            dl_wr_i   = 1'b1;
            dl_addr_i = 25'h300 + 25'(c);
            dl_data_i = 8'hC0 + 8'(c);
            next_cycle();
        end
        total++;
        if (wlog_addr.size() !== n0) begin
            bad++;
            $display("FAIL reads_block_writes: got %0d writes want 0", wlog_addr.size() - n0);
        end
        reset_n_i = 1'b0;
        idle_inputs();
        #2;
        total++;
        if ({mem_we_o, cpu_valid_o, dl_wait_o, load_done_o, overflow_o, hold_reset_o} !== 6'b000001) begin
            bad++;
            $display("FAIL midstream_reset: got we/vld/wait/done/ovf/hold=%b want 000001",
                     {mem_we_o, cpu_valid_o, dl_wait_o, load_done_o, overflow_o, hold_reset_o});
        end
        n0 = wlog_addr.size();
        next_cycle();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        total++;
        if (hold_reset_o !== 1'b1) begin
            bad++;
            $display("FAIL hold_after_release: got %b want 1", hold_reset_o);
        end
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            @(negedge clk_i);
            total++;
            if ({mem_we_o, cpu_valid_o, dl_wait_o, hold_reset_o} !== 4'b0000) begin
                bad++;
                $display("FAIL post_release c=%0d: got we/vld/wait/hold=%b want 0000",
                         c, {mem_we_o, cpu_valid_o, dl_wait_o, hold_reset_o});
            end
        end
        total++;
        if (wlog_addr.size() !== n0) begin
            bad++;
            $display("FAIL no_write_after_reset: got %0d writes want 0", wlog_addr.size() - n0);
        end
        next_cycle();
    endtask

    task automatic test_download;
        int n0;
        n0 = wlog_addr.size();
        for (int c = 0; c < 14; c++) begin
            dl_active_i = (c < 8);
            dl_wr_i     = (c < 8);
            dl_addr_i   = 25'(c);
            dl_data_i   = 8'h11 + 8'(c);
            @(negedge clk_i);
            total++;
            if (dl_wait_o !== 1'b0) begin
                bad++;
                $display("FAIL dl_wait c=%0d: got %b want 0", c, dl_wait_o);
            end
            total++;
            if (load_done_o !== (c == 10)) begin
                bad++;
                $display("FAIL load_done c=%0d: got %b want %b", c, load_done_o, (c == 10));
            end
            next_cycle();
        end
        idle_inputs();
        total++;
        if (wlog_addr.size() !== n0 + 8) begin
            bad++;
            $display("FAIL dl_write_count: got %0d want 8", wlog_addr.size() - n0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (wlog_addr[n0+i] !== i || wlog_data[n0+i] !== 8'h11 + i ||
                    wlog_cyc[n0+i] !== wlog_cyc[n0] + i) begin
                    bad++;
                    $display("FAIL dl_write %0d: got addr=%h data=%h dcyc=%0d want addr=%h data=%h dcyc=%0d",
                             i, wlog_addr[n0+i], wlog_data[n0+i], wlog_cyc[n0+i] - wlog_cyc[n0],
                             i, 8'h11 + i, i);
                end
            end
        end
    endtask

    task automatic test_interleaved;
        int n0;
        for (int a = 0; a < 8; a++) ram[a] = 8'h00;
        n0 = wlog_addr.size();
        for (int c = 0; c < 14; c++) begin
            dl_active_i = (c < 8);
            dl_wr_i     = (c < 8);
            dl_addr_i   = 25'(c);
            dl_data_i   = 8'h11 + 8'(c);
            cpu_req_i   = (c == 6);
            cpu_addr_i  = 15'd3;
            @(negedge clk_i);
            total++;
            if (cpu_valid_o !== (c == 9)) begin
                bad++;
                $display("FAIL il_valid c=%0d: got %b want %b", c, cpu_valid_o, (c == 9));
            end
            if (c == 9) begin
                total++;
                if (cpu_data_o !== 8'h14) begin
                    bad++;
                    $display("FAIL il_data: got %h want 14", cpu_data_o);
                end
            end
            next_cycle();
        end
        idle_inputs();
        total++;
        if (wlog_addr.size() !== n0 + 8) begin
            bad++;
            $display("FAIL il_write_count: got %0d want 8", wlog_addr.size() - n0);
        end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (ram[i] !== 8'h11 + 8'(i)) begin
                bad++;
                $display("FAIL il_ram[%0d]: got %h want %h", i, ram[i], 8'h11 + 8'(i));
            end
        end
    endtask

    task automatic test_full_fifo;
        logic exp_we;
        logic exp_wait;
        logic exp_valid;
        for (int a = 0; a < 4; a++) ram[15'h40 + a] = 8'h00;
        for (int c = 0; c < 16; c++) begin
            dl_active_i = 1'b1;
            dl_wr_i     = (c < 4);
            dl_addr_i   = 25'h40 + 25'(c);
            dl_data_i   = 8'hA0 + 8'(c);
            cpu_req_i   = (c <= 9);
            cpu_addr_i  = 15'h0100;
            @(negedge clk_i);
            exp_we    = (c == 5) || (c >= 11 && c <= 13);
            exp_wait  = (c >= 4 && c <= 11);
            exp_valid = (c >= 3 && c <= 6) || (c >= 8 && c <= 12);
            total++;
            if (mem_we_o !== exp_we) begin
                bad++;
                $display("FAIL ff_we c=%0d: got %b want %b", c, mem_we_o, exp_we);
            end
            if (c == 5) begin
                total++;
                if (mem_addr_o !== 15'h40 || mem_data_o !== 8'hA0) begin
                    bad++;
                    $display("FAIL ff_forced_wr: got addr=%h data=%h want addr=0040 data=a0",
                             mem_addr_o, mem_data_o);
                end
            end
            total++;
            if (dl_wait_o !== exp_wait) begin
                bad++;
                $display("FAIL ff_wait c=%0d: got %b want %b", c, dl_wait_o, exp_wait);
            end
            total++;
            if (cpu_valid_o !== exp_valid) begin
                bad++;
                $display("FAIL ff_valid c=%0d: got %b want %b", c, cpu_valid_o, exp_valid);
            end
            next_cycle();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ram[15'h40 + i] !== 8'hA0 + 8'(i)) begin
                bad++;
                $display("FAIL ff_ram[%0d]: got %h want %h", i, ram[15'h40 + i], 8'hA0 + 8'(i));
            end
        end
        total++;
        if (overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL ff_no_overflow: got %b want 0", overflow_o);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] exp_ram [6];
        exp_ram = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h00, 8'hB5};
        for (int a = 0; a < 6; a++) ram[15'h60 + a] = 8'h00;
        for (int c = 0; c < 16; c++) begin
            dl_active_i = 1'b1;
            dl_wr_i     = (c < 6);
            dl_addr_i   = 25'h60 + 25'(c);
            dl_data_i   = 8'hB0 + 8'(c);
            cpu_req_i   = (c <= 9);
            cpu_addr_i  = 15'h0100;
            @(negedge clk_i);
            total++;
            if (overflow_o !== (c >= 5)) begin
                bad++;
                $display("FAIL ovf c=%0d: got %b want %b", c, overflow_o, (c >= 5));
            end
            next_cycle();
        end
        dl_wr_i   = 1'b0;
        cpu_req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (ram[15'h60 + i] !== exp_ram[i]) begin
                bad++;
                $display("FAIL ovf_ram[%0d]: got %h want %h", i, ram[15'h60 + i], exp_ram[i]);
            end
        end
        dl_active_i = 1'b0;
        next_cycle();
        @(negedge clk_i);
        total++;
        if (overflow_o !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: got %b want 1", overflow_o);
        end
        dl_active_i = 1'b1;
        next_cycle();
        @(negedge clk_i);
        total++;
        if (overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear_on_rise: got %b want 0", overflow_o);
        end
        next_cycle();
    endtask

    task automatic test_out_of_window;
        int n0;
        n0 = wlog_addr.size();
        dl_active_i = 1'b1;
        dl_wr_i     = 1'b1;
        dl_addr_i   = 25'h008000;
        dl_data_i   = 8'hAA;
        next_cycle();
        dl_wr_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            total++;
            if (mem_we_o !== 1'b0 || dl_wait_o !== 1'b0) begin
                bad++;
                $display("FAIL oow_idle c=%0d: got we=%b wait=%b want 0 0", c, mem_we_o, dl_wait_o);
            end
            next_cycle();
        end
        total++;
        if (wlog_addr.size() !== n0) begin
            bad++;
            $display("FAIL oow_writes: got %0d want 0", wlog_addr.size() - n0);
        end
        total++;
        if (ram[0] !== 8'h11) begin
            bad++;
            $display("FAIL oow_ram0: got %h want 11", ram[0]);
        end
        total++;
        if (overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL oow_overflow: got %b want 0", overflow_o);
        end
        idle_inputs();
        next_cycle();
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) ram[a] = 8'h00;
        test_reset();
        test_download();
        test_interleaved();
        test_full_fifo();
        test_overflow();
        test_out_of_window();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
